// File: rtl/pot_bank_ctrl.sv
// pot_bank_ctrl
//   POKEY paddle register bank and scan sequencer. A CPU write to POTGO raises
//   a scan request to every pot scanner; each scanner's one-cycle done pulse
//   drops its request and, one cycle later, its 8-bit result is captured into
//   POTn and its ALLPOT bit is cleared. Channels that have not reported by the
//   end of the timeout window are force-completed with MAX_COUNT.
//
//   state | meaning
//   IDLE  | no scan in flight; a POTGO write (or a pending one) starts a scan
//   SCAN  | requests outstanding or captures pending; tcnt counts scan cycles
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   addr       register address (reads and POTGO decode)
//   wr_en      CPU write strobe (data is irrelevant, only the address matters)
//   rd_en      CPU read strobe
//   pot_rdy    per-channel done pulse from the scanners
//   pot_val    scanner results, channel i in pot_val[8i+7:8i]
//   potgo_out  per-channel scan request level
//   data_out   registered read data
//   allpot     bit i set while channel i is unresolved
//   scan_busy  high while in SCAN
module pot_bank_ctrl #(
    parameter int          NUM_POTS    = 8,
    parameter int          TIMEOUT     = 300,
    parameter logic [7:0]  MAX_COUNT   = 8'hE4,
    parameter logic [3:0]  POTGO_ADDR  = 4'hB,
    parameter logic [3:0]  ALLPOT_ADDR = 4'h8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            addr,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [NUM_POTS-1:0]   pot_rdy,
    input  logic [8*NUM_POTS-1:0] pot_val,
    output logic [NUM_POTS-1:0]   potgo_out,
    output logic [7:0]            data_out,
    output logic [7:0]            allpot,
    output logic                  scan_busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [7:0]          ALL_MASK = 8'((1 << NUM_POTS) - 1);
    localparam logic [NUM_POTS-1:0] ALL_GO   = {NUM_POTS{1'b1}};
    localparam logic [8:0]          TC_LAST  = 9'(TIMEOUT - 1);

    state_t              state;
    logic [7:0]          pot_reg [NUM_POTS];
    logic [NUM_POTS-1:0] cap_pend;
    logic                go_pend;
    logic [8:0]          tcnt;

    logic                potgo_hit;
    logic [NUM_POTS-1:0] rdy_hit;
    logic [NUM_POTS-1:0] to_hit;
    logic [NUM_POTS-1:0] potgo_nxt;
    logic                scan_done;
    logic [7:0]          rd_mux;

    always_comb begin
        potgo_hit = wr_en && (addr == POTGO_ADDR);
        // Only channels still requesting may report; late pulses are ignored.
        rdy_hit   = pot_rdy & potgo_out;
        // On the timeout edge a same-cycle rdy still wins over force-completion.
        to_hit    = '0;
        if (state == SCAN && tcnt == TC_LAST)
            to_hit = potgo_out & ~pot_rdy;
        potgo_nxt = potgo_out & ~rdy_hit & ~to_hit;
        // Exit looks at post-edge values so the final capture and the exit
        // happen on the same edge.
        scan_done = (potgo_nxt == '0) && (rdy_hit == '0);
    end

    always_comb begin
        rd_mux = 8'h00;
        if (addr == ALLPOT_ADDR)
            rd_mux = allpot;
        for (int i = 0; i < NUM_POTS; i++) begin
            if (addr == 4'(i))
                rd_mux = pot_reg[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            potgo_out <= '0;
            cap_pend  <= '0;
            go_pend   <= 1'b0;
            tcnt      <= '0;
            allpot    <= 8'h00;
            data_out  <= 8'h00;
            scan_busy <= 1'b0;
            for (int i = 0; i < NUM_POTS; i++)
                pot_reg[i] <= 8'h00;
        end else begin
            if (rd_en)
                data_out <= rd_mux;

            case (state)
                IDLE: begin
                    if (potgo_hit || go_pend) begin
                        state     <= SCAN;
                        scan_busy <= 1'b1;
                        potgo_out <= ALL_GO;
                        allpot    <= ALL_MASK;
                        tcnt      <= '0;
                        go_pend   <= 1'b0;
                    end
                end

                SCAN: begin
                    if (tcnt != 9'h1FF)
                        tcnt <= tcnt + 9'd1;
                    potgo_out <= potgo_nxt;
                    cap_pend  <= rdy_hit;
                    for (int i = 0; i < NUM_POTS; i++) begin
                        // Scanner result is valid the cycle after its rdy pulse.
                        if (cap_pend[i]) begin
                            pot_reg[i] <= pot_val[8*i +: 8];
                            allpot[i]  <= 1'b0;
                        end
                        if (to_hit[i]) begin
                            pot_reg[i] <= MAX_COUNT;
                            allpot[i]  <= 1'b0;
                        end
                    end
                    if (scan_done) begin
                        if (go_pend) begin
                            potgo_out <= ALL_GO;
                            allpot    <= ALL_MASK;
                            tcnt      <= '0;
                            go_pend   <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            scan_busy <= 1'b0;
                        end
                    end
                    // A new POTGO never disturbs the scan in flight; repeated
                    // writes collapse into one pending request.
                    if (potgo_hit)
                        go_pend <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pot_bank_ctrl.sv
module tb_pot_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  pot_rdy;
    logic [63:0] pot_val;
    logic [7:0]  potgo_out;
    logic [7:0]  data_out;
    logic [7:0]  allpot;
    logic        scan_busy;

    int total = 0;
    int bad   = 0;

    pot_bank_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .pot_rdy   (pot_rdy),
        .pot_val   (pot_val),
        .potgo_out (potgo_out),
        .data_out  (data_out),
        .allpot    (allpot),
        .scan_busy (scan_busy)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel status and a scan-age counter.
    bit      m_scan;
    bit      m_pend;
    int      m_age;
    bit      m_wait [8];
    bit      m_due  [8];
    int      m_reg  [8];
    int      m_dout;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_allpot();
        int v = 0;
        for (int i = 0; i < 8; i++)
            if (m_scan && (m_wait[i] || m_due[i])) v |= (1 << i);
        return v;
    endfunction

    function automatic int m_go();
        int v = 0;
        for (int i = 0; i < 8; i++)
            if (m_scan && m_wait[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic m_start();
        m_age  = 0;
        m_pend = 0;
        for (int i = 0; i < 8; i++) begin
            m_wait[i] = 1;
            m_due[i]  = 0;
        end
    endtask

    task automatic model_step();
        bit hit;
        int old_age;
        bit any;
        bit new_due [8];
        hit = wr_en && (addr == 4'hB);
        if (rst) begin
            m_scan = 0; m_pend = 0; m_age = 0; m_dout = 0;
            for (int i = 0; i < 8; i++) begin
                m_wait[i] = 0; m_due[i] = 0; m_reg[i] = 0;
            end
            return;
        end
        if (rd_en) begin
            if (addr < 8)       m_dout = m_reg[addr];
            else if (addr == 8) m_dout = m_allpot();
            else                m_dout = 0;
        end
        if (!m_scan) begin
            if (hit || m_pend) begin
                m_scan = 1;
                m_start();
            end
            return;
        end
        old_age = m_age;
        if (m_age < 511) m_age++;
        any = 0;
        for (int i = 0; i < 8; i++) begin
            new_due[i] = 0;
            if (m_due[i]) m_reg[i] = int'(pot_val[8*i +: 8]);
            if (m_wait[i] && pot_rdy[i]) begin
                m_wait[i] = 0;
                new_due[i] = 1;
            end else if (m_wait[i] && old_age == 299) begin
                m_wait[i] = 0;
                m_reg[i] = 228;
            end
        end
        for (int i = 0; i < 8; i++) begin
            m_due[i] = new_due[i];
            if (m_wait[i] || m_due[i]) any = 1;
        end
        if (!any) begin
            if (m_pend) m_start();
            else        m_scan = 0;
        end
        if (hit) m_pend = 1;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_val("potgo_out", potgo_out, m_go());
        check_val("allpot",    allpot,    m_allpot());
        check_val("scan_busy", scan_busy, m_scan);
        check_val("data_out",  data_out,  m_dout);
        rst = 0; wr_en = 0; rd_en = 0; pot_rdy = 0;
    endtask

    task automatic potgo();
        addr = 4'hB; wr_en = 1; cyc();
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input string tag);
        addr = a; rd_en = 1; cyc();
        check_val(tag, data_out, exp);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (scan_busy && n < budget) begin
            cyc();
            n++;
        end
        check_val(tag, scan_busy, 1'b0);
    endtask

    initial begin
        rst = 1; addr = 0; wr_en = 0; rd_en = 0; pot_rdy = 0; pot_val = 0;
        cyc();

        // 1: reset in the middle of a scan with a pending POTGO
        potgo();
        potgo();
        check_val("t1_go_mid", potgo_out, 8'hFF);
        rst = 1; cyc();
        check_val("t1_go_rst", potgo_out, 8'h00);
        check_val("t1_busy_rst", scan_busy, 1'b0);
        for (int a = 0; a <= 8; a++) do_read(4'(a), 8'h00, "t1_read");
        repeat (3) cyc();
        check_val("t1_no_restart", scan_busy, 1'b0);

        // 2: single channel report and capture
        potgo();
        pot_rdy = 8'h08; cyc();
        check_val("t2_go", potgo_out, 8'hF7);
        pot_val[31:24] = 8'h42; cyc();
        check_val("t2_allpot", allpot, 8'hF7);
        do_read(4'd3, 8'h42, "t2_read3");
        pot_rdy = 8'hF7; cyc();
        pot_val = {$urandom, $urandom}; pot_val[31:24] = 8'h99; cyc();
        check_val("t2_done", scan_busy, 1'b0);
        do_read(4'd3, 8'h42, "t2_read3_kept");

        // 3: all channels report, the last at cycle 40
        potgo();
        for (int c = 1; c <= 41; c++) begin
            if (c % 5 == 0 && c <= 40) pot_rdy = 8'(1 << (c / 5 - 1));
            pot_val = {$urandom, $urandom};
            cyc();
        end
        check_val("t3_busy", scan_busy, 1'b0);
        check_val("t3_allpot", allpot, 8'h00);

        // 4: channel 5 never reports
        potgo();
        pot_rdy = 8'hDF; cyc();
        pot_val[47:40] = 8'h11; cyc();
        wait_idle(400, "t4_timeout");
        check_val("t4_go", potgo_out, 8'h00);
        check_val("t4_allpot", allpot, 8'h00);
        do_read(4'd5, 8'hE4, "t4_read5");

        // 5: POTGO during a scan restarts right after the final capture
        potgo();
        repeat (9) cyc();
        potgo();
        potgo();
        pot_rdy = 8'hFF; cyc();
        pot_val = {$urandom, $urandom}; cyc();
        check_val("t5_restart_go", potgo_out, 8'hFF);
        check_val("t5_restart_allpot", allpot, 8'hFF);
        check_val("t5_busy", scan_busy, 1'b1);
        pot_rdy = 8'hFF; cyc();
        cyc();
        check_val("t5_no_second", scan_busy, 1'b0);

        // 6: rdy on the timeout edge wins over force-completion
        potgo();
        repeat (299) cyc();
        pot_rdy = 8'h04; cyc();
        check_val("t6_go", potgo_out, 8'h00);
        pot_val[23:16] = 8'h10; cyc();
        check_val("t6_busy", scan_busy, 1'b0);
        do_read(4'd2, 8'h10, "t6_read2");
        do_read(4'd0, 8'hE4, "t6_read0");
        do_read(4'd9, 8'h00, "t6_read9");

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst     = ($urandom_range(0, 599) == 0);
            addr    = ($urandom_range(0, 3) == 0) ? 4'hB : 4'($urandom);
            wr_en   = ($urandom_range(0, 24) == 0);
            rd_en   = $urandom_range(0, 1) == 1;
            for (int i = 0; i < 8; i++)
                pot_rdy[i] = ($urandom_range(0, 39) == 0);
            if (k >= 2000 && k < 3000) pot_rdy = pot_rdy & 8'h7F;
            pot_val = {$urandom, $urandom};
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
